// File: rtl/hyp_trap_if.sv
// rtl/hyp_trap_if.sv - trap request, delegation CSR and commit/redirect signals of the trap sequencer
interface hyp_trap_if #(parameter int XLEN = 64);
  logic            TrapReqM;
  logic            InterruptM;
  logic [4:0]      CauseM;
  logic            FlushM;
  logic [1:0]      PrivilegeModeW;
  logic            VirtModeW;
  logic [XLEN-1:0] MEDELEG_REGW;
  logic [11:0]     MIDELEG_REGW;
  logic [XLEN-1:0] HEDELEG_REGW;
  logic [11:0]     HIDELEG_REGW;
  logic [XLEN-1:0] MTVEC_REGW;
  logic [XLEN-1:0] STVEC_REGW;
  logic [XLEN-1:0] VSTVEC_REGW;
  logic            MTrapM;
  logic            HSTrapM;
  logic            VSTrapM;
  logic [4:0]      NextCauseM;
  logic [1:0]      NextPrivilegeModeM;
  logic            NextVirtModeM;
  logic            TrapRedirectM;
  logic [XLEN-1:0] TrapVectorM;
  logic            TrapAckM;
  logic            BusyM;

  modport master (
    output TrapReqM, InterruptM, CauseM, FlushM, PrivilegeModeW, VirtModeW,
           MEDELEG_REGW, MIDELEG_REGW, HEDELEG_REGW, HIDELEG_REGW,
           MTVEC_REGW, STVEC_REGW, VSTVEC_REGW,
    input  MTrapM, HSTrapM, VSTrapM, NextCauseM, NextPrivilegeModeM, NextVirtModeM,
           TrapRedirectM, TrapVectorM, TrapAckM, BusyM
  );

  modport slave (
    input  TrapReqM, InterruptM, CauseM, FlushM, PrivilegeModeW, VirtModeW,
           MEDELEG_REGW, MIDELEG_REGW, HEDELEG_REGW, HIDELEG_REGW,
           MTVEC_REGW, STVEC_REGW, VSTVEC_REGW,
    output MTrapM, HSTrapM, VSTrapM, NextCauseM, NextPrivilegeModeM, NextVirtModeM,
           TrapRedirectM, TrapVectorM, TrapAckM, BusyM
  );
endinterface

// File: rtl/hyp_trap_ctrl.sv
// rtl/hyp_trap_ctrl.sv - hypervisor trap-delivery sequencer: resolve M/HS/VS target, commit strobe, PC redirect
module hyp_trap_ctrl #(
  parameter int XLEN = 64
) (
  input  logic     clk,
  input  logic     reset,
  hyp_trap_if.slave bus
);
  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RESOLVE  = 2'd1;
  localparam logic [1:0] COMMIT   = 2'd2;
  localparam logic [1:0] REDIRECT = 2'd3;

  localparam logic [1:0] TGT_M  = 2'd0;
  localparam logic [1:0] TGT_HS = 2'd1;
  localparam logic [1:0] TGT_VS = 2'd2;

  logic [1:0]      state;
  logic            intr_q;
  logic [4:0]      cause_q;
  logic [1:0]      mode_q;
  logic            virt_q;
  logic [1:0]      tgt_q;
  logic [4:0]      next_cause_q;
  logic [1:0]      next_priv_q;
  logic            next_virt_q;
  logic [XLEN-1:0] vec_q;

  logic            deleg;
  logic            hdeleg;
  logic            exc_no_vs;
  logic [1:0]      tgt_d;
  logic [4:0]      cause_d;
  logic [15:0]     mideleg_ext;
  logic [15:0]     hideleg_ext;
  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_off;

  always_comb begin
    // Zero-extend to 16 so interrupt causes 12..15 read as not delegated
    mideleg_ext = {4'b0000, bus.MIDELEG_REGW};
    hideleg_ext = {4'b0000, bus.HIDELEG_REGW};
    exc_no_vs = 1'b0;
    case (cause_q)
      5'd9, 5'd10, 5'd11, 5'd20, 5'd21, 5'd22, 5'd23: exc_no_vs = 1'b1;
      default: exc_no_vs = 1'b0;
    endcase
    if (intr_q) begin
      deleg  = ~cause_q[4] & mideleg_ext[cause_q[3:0]];
      hdeleg = ~cause_q[4] & hideleg_ext[cause_q[3:0]];
    end else begin
      deleg  = bus.MEDELEG_REGW[cause_q];
      hdeleg = bus.HEDELEG_REGW[cause_q] & ~exc_no_vs;
    end

    if (mode_q == M_MODE || !deleg) tgt_d = TGT_M;
    else if (virt_q && hdeleg)      tgt_d = TGT_VS;
    else                            tgt_d = TGT_HS;

    // VS sees its own interrupt numbering: VS{SI,TI,EI} map onto S{SI,TI,EI}
    cause_d = cause_q;
    if (tgt_d == TGT_VS && intr_q) begin
      case (cause_q)
        5'd2:    cause_d = 5'd1;
        5'd6:    cause_d = 5'd5;
        5'd10:   cause_d = 5'd9;
        default: cause_d = cause_q;
      endcase
    end

    case (tgt_q)
      TGT_HS:  tvec = bus.STVEC_REGW;
      TGT_VS:  tvec = bus.VSTVEC_REGW;
      default: tvec = bus.MTVEC_REGW;
    endcase
    vec_base = {tvec[XLEN-1:2], 2'b00};
    vec_off  = '0;
    if (tvec[1:0] == 2'b01 && intr_q)
      vec_off = {{(XLEN-7){1'b0}}, next_cause_q, 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      intr_q       <= 1'b0;
      cause_q      <= 5'd0;
      mode_q       <= M_MODE;
      virt_q       <= 1'b0;
      tgt_q        <= TGT_M;
      next_cause_q <= 5'd0;
      next_priv_q  <= M_MODE;
      next_virt_q  <= 1'b0;
      vec_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.TrapReqM) begin
            intr_q  <= bus.InterruptM;
            cause_q <= bus.CauseM;
            mode_q  <= bus.PrivilegeModeW;
            virt_q  <= bus.VirtModeW;
            state   <= RESOLVE;
          end
        end
        RESOLVE: begin
          if (bus.FlushM) begin
            state <= IDLE;
          end else begin
            tgt_q        <= tgt_d;
            next_cause_q <= cause_d;
            next_priv_q  <= (tgt_d == TGT_M) ? M_MODE : S_MODE;
            next_virt_q  <= (tgt_d == TGT_VS);
            state        <= COMMIT;
          end
        end
        COMMIT: begin
          vec_q <= vec_base + vec_off;
          state <= REDIRECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MTrapM             = (state == COMMIT) && (tgt_q == TGT_M);
  assign bus.HSTrapM            = (state == COMMIT) && (tgt_q == TGT_HS);
  assign bus.VSTrapM            = (state == COMMIT) && (tgt_q == TGT_VS);
  assign bus.NextCauseM         = next_cause_q;
  assign bus.NextPrivilegeModeM = next_priv_q;
  assign bus.NextVirtModeM      = next_virt_q;
  assign bus.TrapRedirectM      = (state == REDIRECT);
  assign bus.TrapVectorM        = vec_q;
  // Flush acks in the same cycle so the requester can drop TrapReqM before IDLE samples it
  assign bus.TrapAckM           = (state == REDIRECT) || (state == RESOLVE && bus.FlushM);
  assign bus.BusyM              = (state != IDLE);
endmodule
